// File: rtl/small_ip_pkg.sv
// Shared constants for the DC encoder: colour-space coefficients, JPEG DC
// Huffman prefix tables and the magnitude category helper.
package small_ip_pkg;

    localparam logic signed [17:0] Y_R  = 18'sd77;
    localparam logic signed [17:0] Y_G  = 18'sd150;
    localparam logic signed [17:0] Y_B  = 18'sd29;
    localparam logic signed [17:0] CB_R = -18'sd43;
    localparam logic signed [17:0] CB_G = -18'sd85;
    localparam logic signed [17:0] CB_B = 18'sd128;
    localparam logic signed [17:0] CR_R = 18'sd128;
    localparam logic signed [17:0] CR_G = -18'sd107;
    localparam logic signed [17:0] CR_B = -18'sd21;

    // Index 0 is the leftmost element, so entry k is the code for category k.
    localparam logic [0:11][10:0] LUMA_CODE = {
        11'd0, 11'd2, 11'd3, 11'd4, 11'd5, 11'd6,
        11'd14, 11'd30, 11'd62, 11'd126, 11'd254, 11'd510
    };
    localparam logic [0:11][3:0] LUMA_LEN = {
        4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3,
        4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9
    };
    localparam logic [0:11][10:0] CHROMA_CODE = {
        11'd0, 11'd1, 11'd2, 11'd6, 11'd14, 11'd30,
        11'd62, 11'd126, 11'd254, 11'd510, 11'd1022, 11'd2046
    };
    localparam logic [0:11][3:0] CHROMA_LEN = {
        4'd2, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5,
        4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11
    };

    // Bit length of an unsigned magnitude (0 for zero).
    function automatic logic [3:0] dc_category(input logic [11:0] mag);
        logic [3:0] cat;
        cat = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (mag[i]) cat = 4'(i + 1);
        end
        return cat;
    endfunction

endpackage

// File: rtl/dc_encoder.sv
// One colour component: block accumulator, rounded DC quantiser, DPCM against
// the previous block and JPEG DC Huffman packing, in three register stages.
module dc_encoder
    import small_ip_pkg::*;
#(
    parameter int Q         = 16,
    parameter bit IS_CHROMA = 1'b0
) (
    input  logic              clk_0,
    input  logic              rst,
    input  logic signed [8:0] sample,
    input  logic              first,
    input  logic              last,
    output logic [25:0]       code,
    output logic [4:0]        bits,
    output logic              sync
);

    localparam logic [15:0] HALF_STEP = 16'(4 * Q);
    localparam logic [15:0] STEP      = 16'(8 * Q);

    logic signed [14:0] acc_q, acc_d, sum_q, sum_d;
    logic               sum_v_q, sum_v_d;
    logic signed [10:0] prev_q, prev_d;
    logic signed [11:0] diff_q, diff_d;
    logic               diff_v_q, diff_v_d;
    logic [25:0]        code_q, code_d;
    logic [4:0]         bits_q, bits_d;
    logic               sync_q, sync_d;

    logic [14:0]        mag;
    logic [10:0]        quo;
    logic signed [10:0] q_val;
    logic [11:0]        diff_mag;
    logic [11:0]        suffix_src;
    logic [3:0]         cat;
    logic [10:0]        pre_code;
    logic [3:0]         pre_len;

    // Stage 1: the block total is captured together with the last sample.
    always_comb begin
        acc_d   = (first ? 15'sd0 : acc_q) + {{6{sample[8]}}, sample};
        sum_d   = sum_q;
        sum_v_d = last;
        if (last) sum_d = acc_d;
    end

    // Stage 2: round-half-away-from-zero on the magnitude, then DPCM.
    always_comb begin
        mag      = sum_q[14] ? $unsigned(-sum_q) : $unsigned(sum_q);
        quo      = 11'(({1'b0, mag} + HALF_STEP) / STEP);
        q_val    = sum_q[14] ? -$signed(quo) : $signed(quo);
        diff_d   = diff_q;
        prev_d   = prev_q;
        diff_v_d = sum_v_q;
        if (sum_v_q) begin
            diff_d = {q_val[10], q_val} - {prev_q[10], prev_q};
            prev_d = q_val;
        end
    end

    // Stage 3: prefix from the table, suffix is diff (or diff-1 when negative).
    always_comb begin
        diff_mag   = diff_q[11] ? $unsigned(-diff_q) : $unsigned(diff_q);
        suffix_src = diff_q[11] ? $unsigned(diff_q - 12'sd1) : $unsigned(diff_q);
        cat        = dc_category(diff_mag);
        pre_code   = IS_CHROMA ? CHROMA_CODE[cat] : LUMA_CODE[cat];
        pre_len    = IS_CHROMA ? CHROMA_LEN[cat] : LUMA_LEN[cat];
        code_d     = code_q;
        bits_d     = bits_q;
        sync_d     = diff_v_q;
        if (diff_v_q) begin
            code_d = ({15'd0, pre_code} << cat)
                   | ({14'd0, suffix_src} & ((26'd1 << cat) - 26'd1));
            bits_d = {1'b0, pre_len} + {1'b0, cat};
        end
    end

    always_ff @(posedge clk_0 or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            sum_q    <= '0;
            sum_v_q  <= 1'b0;
            prev_q   <= '0;
            diff_q   <= '0;
            diff_v_q <= 1'b0;
            code_q   <= '0;
            bits_q   <= '0;
            sync_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            sum_q    <= sum_d;
            sum_v_q  <= sum_v_d;
            prev_q   <= prev_d;
            diff_q   <= diff_d;
            diff_v_q <= diff_v_d;
            code_q   <= code_d;
            bits_q   <= bits_d;
            sync_q   <= sync_d;
        end
    end

    assign code = code_q;
    assign bits = bits_q;
    assign sync = sync_q;

endmodule

// File: rtl/small_ip.sv
// RGB pixel stream to per-block JPEG DC codewords for Y, Cb and Cr.
// Blocks of 64 pixels arrive back to back; one pixel per clock.
module small_ip
    import small_ip_pkg::*;
#(
    parameter int QDC_Y = 16,
    parameter int QDC_C = 17
) (
    input  logic        clk_0,
    input  logic        rst,
    input  logic [7:0]  R_in,
    input  logic [7:0]  G_in,
    input  logic [7:0]  B_in,
    output logic [25:0] encoded_y,
    output logic [25:0] encoded_cb,
    output logic [25:0] encoded_cr,
    output logic [4:0]  encoded_y_bits,
    output logic [4:0]  encoded_cb_bits,
    output logic [4:0]  encoded_cr_bits,
    output logic        sync_y,
    output logic        sync_cb,
    output logic        sync_cr
);

    logic [5:0]         cnt_q, cnt_d;
    logic               first, last;
    logic signed [17:0] r_s, g_s, b_s;
    logic signed [17:0] y_sum, cb_sum, cr_sum;
    logic signed [8:0]  sample [3];
    logic [25:0]        enc_code [3];
    logic [4:0]         enc_bits [3];
    logic               enc_sync [3];

    always_comb begin
        r_s       = $signed({10'd0, R_in});
        g_s       = $signed({10'd0, G_in});
        b_s       = $signed({10'd0, B_in});
        y_sum     = Y_R * r_s + Y_G * g_s + Y_B * b_s;
        cb_sum    = CB_R * r_s + CB_G * g_s + CB_B * b_s;
        cr_sum    = CR_R * r_s + CR_G * g_s + CR_B * b_s;
        sample[0] = 9'(y_sum >>> 8) - 9'sd128;
        sample[1] = 9'(cb_sum >>> 8);
        sample[2] = 9'(cr_sum >>> 8);
        cnt_d     = cnt_q + 6'd1;
        first     = (cnt_q == 6'd0);
        last      = (cnt_q == 6'd63);
    end

    // Counter wraps 63 -> 0 on its own, so blocks are seamless.
    always_ff @(posedge clk_0 or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_enc
        dc_encoder #(
            .Q         (gi == 0 ? QDC_Y : QDC_C),
            .IS_CHROMA (gi != 0)
        ) u_enc (
            .clk_0  (clk_0),
            .rst    (rst),
            .sample (sample[gi]),
            .first  (first),
            .last   (last),
            .code   (enc_code[gi]),
            .bits   (enc_bits[gi]),
            .sync   (enc_sync[gi])
        );
    end

    assign encoded_y       = enc_code[0];
    assign encoded_cb      = enc_code[1];
    assign encoded_cr      = enc_code[2];
    assign encoded_y_bits  = enc_bits[0];
    assign encoded_cb_bits = enc_bits[1];
    assign encoded_cr_bits = enc_bits[2];
    assign sync_y          = enc_sync[0];
    assign sync_cb         = enc_sync[1];
    assign sync_cr         = enc_sync[2];

endmodule

// File: tb/tb_small_ip.sv
// Bench for small_ip: directed colour blocks, reset behaviour and randomized
// back-to-back blocks against a behavioural DC-coding model.
module tb_small_ip;

    localparam int QY = 16;
    localparam int QC = 17;

    logic        clk_0 = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  R_in = '0, G_in = '0, B_in = '0;
    logic [25:0] encoded_y, encoded_cb, encoded_cr;
    logic [4:0]  encoded_y_bits, encoded_cb_bits, encoded_cr_bits;
    logic        sync_y, sync_cb, sync_cr;

    always #5 clk_0 = ~clk_0;

    small_ip #(.QDC_Y(QY), .QDC_C(QC)) dut (
        .clk_0           (clk_0),
        .rst             (rst),
        .R_in            (R_in),
        .G_in            (G_in),
        .B_in            (B_in),
        .encoded_y       (encoded_y),
        .encoded_cb      (encoded_cb),
        .encoded_cr      (encoded_cr),
        .encoded_y_bits  (encoded_y_bits),
        .encoded_cb_bits (encoded_cb_bits),
        .encoded_cr_bits (encoded_cr_bits),
        .sync_y          (sync_y),
        .sync_cb         (sync_cb),
        .sync_cr         (sync_cr)
    );

    logic [25:0] got_code [3];
    logic [4:0]  got_bits [3];
    logic        got_sync [3];
    assign got_code[0] = encoded_y;
    assign got_code[1] = encoded_cb;
    assign got_code[2] = encoded_cr;
    assign got_bits[0] = encoded_y_bits;
    assign got_bits[1] = encoded_cb_bits;
    assign got_bits[2] = encoded_cr_bits;
    assign got_sync[0] = sync_y;
    assign got_sync[1] = sync_cb;
    assign got_sync[2] = sync_cr;

    int checks = 0;
    int passes = 0;

    // Reference model state
    int          pos;
    int          acc [3];
    int          prev [3];
    logic [25:0] exp_code [3];
    int          exp_bits [3];
    int          base_r, base_g, base_b;

    string LUMA [12] = '{"00", "010", "011", "100", "101", "110", "1110",
                         "11110", "111110", "1111110", "11111110", "111111110"};
    string CHROMA [12] = '{"00", "01", "10", "110", "1110", "11110", "111110",
                           "1111110", "11111110", "111111110", "1111111110",
                           "11111111110"};

    task automatic model_reset();
        pos = 0;
        for (int c = 0; c < 3; c++) begin
            acc[c]  = 0;
            prev[c] = 0;
        end
    endtask

    // Round S/(8Q) half away from zero, DPCM, then prefix string + suffix bits.
    task automatic encode(input int s, input int qd, input bit chroma, input int c);
        int q, diff, m, cat, v;
        logic [25:0] w;
        string p;
        if (s >= 0) q = (s + 4 * qd) / (8 * qd);
        else        q = -((-s + 4 * qd) / (8 * qd));
        diff = q - prev[c];
        prev[c] = q;
        m = (diff < 0) ? -diff : diff;
        cat = 0;
        while (m > 0) begin
            cat++;
            m = m / 2;
        end
        p = chroma ? CHROMA[cat] : LUMA[cat];
        w = '0;
        for (int i = 0; i < p.len(); i++)
            w = (w << 1) | ((p[i] == 8'h31) ? 26'd1 : 26'd0);
        v = (diff >= 0) ? diff : diff - 1;
        for (int i = cat - 1; i >= 0; i--)
            w = (w << 1) | 26'((v >> i) & 1);
        exp_code[c] = w;
        exp_bits[c] = p.len() + cat;
    endtask

    task automatic drive_pixel(input int r, input int g, input int b);
        int v [3];
        R_in = 8'(r);
        G_in = 8'(g);
        B_in = 8'(b);
        @(posedge clk_0);
        #1;
        v[0] = ((77 * r + 150 * g + 29 * b) >> 8) - 128;
        v[1] = (-43 * r - 85 * g + 128 * b) >>> 8;
        v[2] = (128 * r - 107 * g - 21 * b) >>> 8;
        for (int c = 0; c < 3; c++)
            acc[c] = (pos == 0) ? v[c] : acc[c] + v[c];
        if (pos == 63)
            for (int c = 0; c < 3; c++)
                encode(acc[c], (c == 0) ? QY : QC, c != 0, c);
        pos = (pos + 1) % 64;
    endtask

    function automatic int clamp8(input int x);
        return (x < 0) ? 0 : ((x > 255) ? 255 : x);
    endfunction

    // mode: 0 grey, 1 white, 2 black, 3 red, other = noisy random base colour
    task automatic feed(input int n, input int mode);
        int r, g, b;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0: begin r = 128; g = 128; b = 128; end
                1: begin r = 255; g = 255; b = 255; end
                2: begin r = 0;   g = 0;   b = 0;   end
                3: begin r = 255; g = 0;   b = 0;   end
                default: begin
                    r = clamp8(base_r + int'($urandom_range(0, 31)) - 16);
                    g = clamp8(base_g + int'($urandom_range(0, 31)) - 16);
                    b = clamp8(base_b + int'($urandom_range(0, 31)) - 16);
                end
            endcase
            drive_pixel(r, g, b);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk_0);
        model_reset();
        @(negedge clk_0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            R_in = 8'($urandom);
            G_in = 8'($urandom);
            B_in = 8'($urandom);
            @(posedge clk_0);
            #1;
            checks++;
            if ({encoded_y, encoded_cb, encoded_cr, encoded_y_bits, encoded_cb_bits,
                 encoded_cr_bits, sync_y, sync_cb, sync_cr} !== '0)
                $display("FAIL reset_outputs cycle %0d: got y=%h cb=%h cr=%h syncs=%b%b%b, want all 0",
                         i, encoded_y, encoded_cb, encoded_cr, sync_y, sync_cb, sync_cr);
            else passes++;
        end
        $display("reset: %0d idle cycles checked", 8);
    endtask

    task automatic test_directed(input string name, input int mode,
                                 input logic [25:0] ry, input int ryb,
                                 input logic [25:0] rcb, input int rcbb,
                                 input logic [25:0] rcr, input int rcrb);
        logic [25:0] ref_code [3];
        int ref_bits [3];
        ref_code[0] = ry;  ref_bits[0] = ryb;
        ref_code[1] = rcb; ref_bits[1] = rcbb;
        ref_code[2] = rcr; ref_bits[2] = rcrb;
        do_reset();
        feed(64, mode);
        feed(1, mode);  // edge 65
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (got_sync[c] !== 1'b0)
                $display("FAIL %s_sync_early comp%0d: got %b want 0", name, c, got_sync[c]);
            else passes++;
        end
        feed(1, mode);  // edge 66
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (got_sync[c] !== 1'b1)
                $display("FAIL %s_sync comp%0d: got %b want 1", name, c, got_sync[c]);
            else passes++;
            checks++;
            if (got_code[c] !== ref_code[c] || got_code[c] !== exp_code[c])
                $display("FAIL %s_code comp%0d: got %h want %h (model %h)",
                         name, c, got_code[c], ref_code[c], exp_code[c]);
            else passes++;
            checks++;
            if (int'(got_bits[c]) != ref_bits[c] || int'(got_bits[c]) != exp_bits[c])
                $display("FAIL %s_bits comp%0d: got %0d want %0d (model %0d)",
                         name, c, got_bits[c], ref_bits[c], exp_bits[c]);
            else passes++;
        end
        feed(1, mode);  // edge 67: pulse over, codeword held
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (got_sync[c] !== 1'b0 || got_code[c] !== ref_code[c])
                $display("FAIL %s_hold comp%0d: got sync=%b code=%h want sync=0 code=%h",
                         name, c, got_sync[c], got_code[c], ref_code[c]);
            else passes++;
        end
        $display("%s block: y=%h/%0d cb=%h/%0d cr=%h/%0d", name, encoded_y, encoded_y_bits,
                 encoded_cb, encoded_cb_bits, encoded_cr, encoded_cr_bits);
    endtask

    // Continues the stream straight after a white first block.
    task automatic test_second_block();
        feed(64 - pos, 1);
        feed(2, 1);
        checks++;
        if (sync_y !== 1'b1 || encoded_y !== 26'h0 || encoded_y_bits !== 5'd2
            || encoded_y !== exp_code[0])
            $display("FAIL white_second_y: got sync=%b y=%h bits=%0d want sync=1 y=0 bits=2",
                     sync_y, encoded_y, encoded_y_bits);
        else passes++;
        $display("white second block: y=%h/%0d", encoded_y, encoded_y_bits);
    endtask

    task automatic test_reset_mid_block();
        do_reset();
        feed(64, 1);
        feed(30, 1);
        rst = 1'b1;
        #1;
        checks++;
        if ({encoded_y, encoded_cb, encoded_cr, encoded_y_bits, encoded_cb_bits,
             encoded_cr_bits, sync_y, sync_cb, sync_cr} !== '0)
            $display("FAIL midreset_async_clear: got y=%h bits=%0d want 0", encoded_y, encoded_y_bits);
        else passes++;
        model_reset();
        repeat (3) begin
            R_in = 8'($urandom);
            @(posedge clk_0);
            #1;
            checks++;
            if ({sync_y, sync_cb, sync_cr} !== 3'b000 || encoded_y !== '0)
                $display("FAIL midreset_hold: got syncs=%b%b%b y=%h want 0", sync_y, sync_cb, sync_cr, encoded_y);
            else passes++;
        end
        @(negedge clk_0);
        rst = 1'b0;
        feed(64, 1);
        feed(2, 1);
        checks++;
        if (sync_y !== 1'b1 || encoded_y !== 26'hF40 || encoded_y_bits !== 5'd12)
            $display("FAIL midreset_white_y: got sync=%b y=%h bits=%0d want sync=1 y=f40 bits=12",
                     sync_y, encoded_y, encoded_y_bits);
        else passes++;
        $display("white after mid-block reset: y=%h/%0d", encoded_y, encoded_y_bits);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int blk = 0; blk < 8; blk++) begin
            base_r = $urandom_range(0, 255);
            base_g = $urandom_range(0, 255);
            base_b = $urandom_range(0, 255);
            feed(64 - pos, 4);
            feed(1, 4);
            checks++;
            if ({sync_y, sync_cb, sync_cr} !== 3'b000)
                $display("FAIL b2b_sync_early blk%0d: got %b%b%b want 000", blk, sync_y, sync_cb, sync_cr);
            else passes++;
            feed(1, 4);
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (got_sync[c] !== 1'b1 || got_code[c] !== exp_code[c]
                    || int'(got_bits[c]) != exp_bits[c])
                    $display("FAIL b2b_block blk%0d comp%0d: got sync=%b code=%h bits=%0d want sync=1 code=%h bits=%0d",
                             blk, c, got_sync[c], got_code[c], got_bits[c], exp_code[c], exp_bits[c]);
                else passes++;
            end
            $display("b2b block %0d: y=%h/%0d cb=%h/%0d cr=%h/%0d", blk, encoded_y, encoded_y_bits,
                     encoded_cb, encoded_cb_bits, encoded_cr, encoded_cr_bits);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_directed("grey",  0, 26'h0,   2,  26'h0,   2,  26'h0,   2);
        test_directed("white", 1, 26'hF40, 12, 26'h0,   2,  26'h0,   2);
        test_second_block();
        test_directed("black", 2, 26'hF3F, 12, 26'h0,   2,  26'h0,   2);
        test_directed("red",   3, 26'hC5,  8,  26'h3CB, 10, 26'hFBC, 12);
        test_reset_mid_block();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/small_ip.md
SMALL_IP -- requirements
Module: small_ip

Interface
REQ-001 clk_0  in  1  sole clock; all state updates on its rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 R_in, G_in, B_in  in  8 each  unsigned pixel colour; one pixel sampled every clk_0 edge while rst=0.
REQ-004 encoded_y, encoded_cb, encoded_cr  out  26 each  codeword, right-aligned, bit [n-1] sent first, unused upper bits 0.
REQ-005 encoded_y_bits, encoded_cb_bits, encoded_cr_bits  out  5 each  valid codeword length n, 2..22.
REQ-006 sync_y, sync_cb, sync_cr  out  1 each  one-cycle pulse marking new codeword; all three pulse together.
REQ-007 Parameter QDC_Y, default 16, luminance DC quantiser, 1..255.
REQ-008 Parameter QDC_C, default 17, chrominance DC quantiser, 1..255.

Function
REQ-009 Input is a continuous stream of 8x8 blocks, 64 pixels each, raster order; a 6-bit counter tracks position and wraps 63->0 with no gap cycle.
REQ-010 Y = ((77R+150G+29B)>>8) - 128; Cb = (-43R-85G+128B)>>>8; Cr = (128R-107G-21B)>>>8 (arithmetic shift); each signed 9-bit.
REQ-011 Per component, accumulate the 64 samples into a signed 15-bit sum S; the accumulator restarts at pixel 0 of each block.
REQ-012 Quantised DC q = sign(S)*floor((|S|+4Q)/(8Q)), i.e. round(S/8/Q), half away from zero; Q = QDC_Y for Y, QDC_C for Cb/Cr; q is signed 11-bit.
REQ-013 diff = q - prev, signed 12-bit; prev = previous block's q for the same component, and is updated to q after each block.
REQ-014 Category SSSS = bit length of |diff| (0 for diff=0), range 0..11.
REQ-015 Prefix = standard JPEG DC Huffman code for SSSS; luminance table for Y, chrominance table for Cb/Cr.
REQ-016 Luminance codes, SSSS 0..11: 00,010,011,100,101,110,1110,11110,111110,1111110,11111110,111111110.
REQ-017 Chrominance codes, SSSS 0..11: 00,01,10,110,1110,11110,111110,1111110,11111110,111111110,1111111110,11111111110.
REQ-018 Suffix = low SSSS bits of diff if diff>=0, else low SSSS bits of (diff-1); no suffix when SSSS=0; codeword = prefix followed by suffix; n = prefix length + SSSS.
REQ-019 Latency: if the 64th pixel of a block is sampled at edge N, the encoded_* and *_bits registers update at edge N+2 and sync_* is high from N+2 to N+3.
REQ-020 encoded_* and *_bits hold their values between sync pulses.
REQ-021 Simultaneous events: the first pixel of the next block is accumulated at edge N+1, concurrently with the encoding of the previous block; no pixels are lost.

Reset
REQ-022 While rst=1, all outputs are 0, the pixel counter is 0, all accumulators are 0, all prev predictors are 0, and the pipeline stages are cleared.
REQ-023 Reset asserted mid-block discards the partial block; the first edge with rst=0 samples pixel 0 of a new block.

Structure
REQ-024 Package small_ip_pkg holds the colour coefficients, both Huffman tables (code and length arrays), and a category function.
REQ-025 One sub-module, dc_encoder, covers accumulator, quantiser/rounder, DPCM and Huffman packing; it is parameterised by Q and a luma/chroma select, and is instantiated three times.

Verification
REQ-026 rst=1 with any input -> all outputs 0, no sync pulses.
REQ-027 First block after reset, all pixels R=G=B=128 -> each codeword 0x0, n=2, syncs high at edge 66 after reset release (edge 1 = pixel 0).
REQ-028 First block, all pixels 255,255,255 -> encoded_y=0xF40, y_bits=12; Cb/Cr 0x0, n=2. A second identical block -> encoded_y=0x0, y_bits=2.
REQ-029 First block, all pixels 0,0,0 -> encoded_y=0xF3F, y_bits=12.
REQ-030 First block, all pixels 255,0,0 -> encoded_y=0xC5 (n=8), encoded_cb=0x3CB (n=10), encoded_cr=0xFBC (n=12).
REQ-031 Reset asserted at pixel 30 of a white block, then released, then a full white block -> encoded_y=0xF40 (predictor was cleared).
